// File: rtl/dnn_sched_pkg.sv
// ---------------------------------------------------------------------------
// dnn_sched_pkg
//   Shared declarations for the inference job scheduler:
//     sched_state_t   - scheduler FSM state encoding
//     NUM_CLASSES_DEF - default number of engine class outputs
//     CLASS_NONE      - class index reported when a job is aborted
//     WDOG_W          - width of the RUN watchdog counter
// ---------------------------------------------------------------------------
package dnn_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLEAR  = 3'd2,
        S_START  = 3'd3,
        S_RUN    = 3'd4,
        S_ARGMAX = 3'd5,
        S_RESULT = 3'd6
    } sched_state_t;

    localparam int         NUM_CLASSES_DEF = 10;
    localparam logic [3:0] CLASS_NONE      = 4'hF;
    localparam int         WDOG_W          = 16;

endpackage

// File: rtl/dnn_argmax_seq.sv
// ---------------------------------------------------------------------------
// dnn_argmax_seq
//   Sequential argmax over the engine class scores. On 'load' the scores are
//   captured into a local array and a scan starts; one index is examined per
//   cycle. The best entry is replaced only on a strictly greater signed score,
//   so ties resolve to the lowest index. 'scan_done' pulses for one cycle once
//   the last index has been folded into best_idx/best_score.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         capture scores_in and start a new scan
//   scores_in    NUM_CLASSES packed signed scores, class i at [i*DATA_WIDTH +: DATA_WIDTH]
//   best_idx     index of the winning class
//   best_score   score of the winning class
//   scan_done    one-cycle pulse: best_idx/best_score are final
// ---------------------------------------------------------------------------
module dnn_argmax_seq
    import dnn_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in,
    output logic [3:0]                        best_idx,
    output logic signed [DATA_WIDTH-1:0]      best_score,
    output logic                              scan_done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    logic signed [DATA_WIDTH-1:0] score_mem [NUM_CLASSES];
    logic [3:0]                   idx;
    logic                         scanning;
    logic signed [DATA_WIDTH-1:0] cur_score;

    assign cur_score = score_mem[idx];

    // Score snapshot: pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_mem[i] <= signed'(scores_in[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            scanning   <= 1'b0;
            scan_done  <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
        end else begin
            scan_done <= 1'b0;
            if (load) begin
                idx      <= '0;
                scanning <= 1'b1;
            end else if (scanning) begin
                // Index 0 seeds the best unconditionally; later entries need a strict win.
                if ((idx == 4'd0) || (cur_score > best_score)) begin
                    best_idx   <= idx;
                    best_score <= cur_score;
                end
                if (idx == LAST_IDX) begin
                    scanning  <= 1'b0;
                    scan_done <= 1'b1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/dnn_infer_sched.sv
// ---------------------------------------------------------------------------
// dnn_infer_sched
//   Job sequencer and memory-port arbiter for the ReLU inference engine.
//   The single memory port is owned either by the host loader (LOAD, after
//   host_gnt rises) or by the engine read address. A job clears the engine,
//   starts it, waits for done under a watchdog, scans the class scores for
//   the argmax and presents the result on a valid/ready interface.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   host_req/host_gnt               host port request (level) / registered grant
//   host_we/host_addr/host_wdata    host memory access
//   go_valid/go_ready               job request handshake
//   dnn_start/dnn_reset             one-cycle engine start / clear pulses
//   dnn_done                        engine done level
//   dnn_mem_addr                    engine read address
//   dnn_out                         engine class scores, class i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mem_addr/mem_wdata/mem_we       shared memory port
//   res_valid/res_ready             result handshake
//   res_class/res_score/res_timeout classification result (4'hF / 0 / 1 on abort)
// ---------------------------------------------------------------------------
module dnn_infer_sched
    import dnn_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int NUM_CLASSES    = NUM_CLASSES_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              host_req,
    output logic                              host_gnt,
    input  logic                              host_we,
    input  logic [ADDR_WIDTH-1:0]             host_addr,
    input  logic [DATA_WIDTH-1:0]             host_wdata,
    input  logic                              go_valid,
    output logic                              go_ready,
    output logic                              dnn_start,
    output logic                              dnn_reset,
    input  logic                              dnn_done,
    input  logic [ADDR_WIDTH-1:0]             dnn_mem_addr,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] dnn_out,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic                              mem_we,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [3:0]                        res_class,
    output logic signed [DATA_WIDTH-1:0]      res_score,
    output logic                              res_timeout
);

    localparam logic [WDOG_W-1:0] TIMEOUT_VAL = WDOG_W'(TIMEOUT_CYCLES);

    sched_state_t                 state, state_next;
    logic                         gnt_next;
    logic [WDOG_W-1:0]            wdog, wdog_next, wdog_inc;
    logic [3:0]                   class_next;
    logic signed [DATA_WIDTH-1:0] score_next;
    logic                         timeout_next;
    logic                         scan_load;
    logic [3:0]                   best_idx;
    logic signed [DATA_WIDTH-1:0] best_score;
    logic                         scan_done;

    assign wdog_inc = wdog + WDOG_W'(1);

    dnn_argmax_seq #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .load       (scan_load),
        .scores_in  (dnn_out),
        .best_idx   (best_idx),
        .best_score (best_score),
        .scan_done  (scan_done)
    );

    // Pulses and result-valid decode straight from the state register, so
    // they are glitch-free and fall to zero the instant rst is asserted.
    assign dnn_reset = (state == S_CLEAR);
    assign dnn_start = (state == S_START);
    assign res_valid = (state == S_RESULT);
    // Host wins over a simultaneous go request.
    assign go_ready  = (state == S_IDLE) && !host_req;

    // Memory port: the engine only ever reads.
    assign mem_addr  = host_gnt ? host_addr : dnn_mem_addr;
    assign mem_we    = host_gnt && host_we;
    assign mem_wdata = host_wdata;

    always_comb begin
        state_next   = state;
        gnt_next     = 1'b0;
        wdog_next    = wdog;
        class_next   = res_class;
        score_next   = res_score;
        timeout_next = res_timeout;
        scan_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (host_req) begin
                    state_next = S_LOAD;
                end else if (go_valid) begin
                    state_next = S_CLEAR;
                end
            end
            S_LOAD: begin
                // Grant follows the request one cycle after entry and drops
                // on the same edge that returns to IDLE.
                if (host_req) begin
                    gnt_next = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_next = S_START;
            end
            S_START: begin
                wdog_next  = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                wdog_next = wdog_inc;
                // done takes priority over an expiring watchdog
                if (dnn_done) begin
                    scan_load  = 1'b1;
                    state_next = S_ARGMAX;
                end else if (wdog_inc == TIMEOUT_VAL) begin
                    timeout_next = 1'b1;
                    class_next   = CLASS_NONE;
                    score_next   = '0;
                    state_next   = S_RESULT;
                end
            end
            S_ARGMAX: begin
                if (scan_done) begin
                    timeout_next = 1'b0;
                    class_next   = best_idx;
                    score_next   = best_score;
                    state_next   = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            host_gnt    <= 1'b0;
            wdog        <= '0;
            res_class   <= '0;
            res_score   <= '0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            host_gnt    <= gnt_next;
            wdog        <= wdog_next;
            res_class   <= class_next;
            res_score   <= score_next;
            res_timeout <= timeout_next;
        end
    end

endmodule

// File: tb/tb_dnn_infer_sched.sv
module tb_dnn_infer_sched;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int NC  = 10;
    localparam int TMO = 50;

    typedef struct packed {
        logic [3:0]    cls;
        logic [DW-1:0] score;
        logic          tmo;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             host_req;
    logic             host_gnt;
    logic             host_we;
    logic [AW-1:0]    host_addr;
    logic [DW-1:0]    host_wdata;
    logic             go_valid;
    logic             go_ready;
    logic             dnn_start;
    logic             dnn_reset;
    logic             dnn_done;
    logic [AW-1:0]    dnn_mem_addr;
    logic [NC*DW-1:0] dnn_out;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_we;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_class;
    logic [DW-1:0]    res_score;
    logic             res_timeout;

    int   tests = 0;
    int   fails = 0;
    int   cyc_cnt = 0;
    int   eng_delay = -1;
    int   eng_cnt = 0;
    logic eng_busy = 1'b0;
    int   n_rst_pulses = 0;
    int   n_start_pulses = 0;
    int   cur_sc [NC];
    exp_t sb [$];

    dnn_infer_sched #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_CLASSES    (NC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_req     (host_req),
        .host_gnt     (host_gnt),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .go_valid     (go_valid),
        .go_ready     (go_ready),
        .dnn_start    (dnn_start),
        .dnn_reset    (dnn_reset),
        .dnn_done     (dnn_done),
        .dnn_mem_addr (dnn_mem_addr),
        .dnn_out      (dnn_out),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_class    (res_class),
        .res_score    (res_score),
        .res_timeout  (res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub engine: done rises eng_delay cycles after the start pulse, never if eng_delay < 0.
    initial dnn_done = 1'b0;
    always @(posedge clk) begin
        if (dnn_reset) begin
            eng_busy <= 1'b0;
            dnn_done <= 1'b0;
        end else if (dnn_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 1;
        end else if (eng_busy) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_delay >= 0 && eng_cnt >= eng_delay) dnn_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (dnn_reset) n_rst_pulses++;
        if (dnn_start) n_start_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=hang required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc_cnt++;
    endtask

    task automatic set_scores();
        for (int i = 0; i < NC; i++) dnn_out[i*DW +: DW] = 8'(cur_sc[i]);
    endtask

    function automatic exp_t argmax_model();
        exp_t r;
        int   bi = 0;
        int   bs = cur_sc[0];
        for (int i = 1; i < NC; i++) begin
            if (cur_sc[i] > bs) begin
                bi = i;
                bs = cur_sc[i];
            end
        end
        r.cls   = 4'(bi);
        r.score = 8'(bs);
        r.tmo   = 1'b0;
        return r;
    endfunction

    // One full job: go, engine run, result with 'bp' cycles of backpressure.
    // hreq_at >= 0 raises host_req that many cycles into the wait.
    task automatic do_job(input int delay, input int bp, input int hreq_at);
        exp_t want;
        int   n_done;
        int   n_start;
        bit   got;
        eng_delay = delay;
        set_scores();
        if (delay < 0) want = '{cls: 4'hF, score: 8'h00, tmo: 1'b1};
        else           want = argmax_model();
        sb.push_back(want);
        go_valid = 1'b1;
        chk("go_ready_idle", go_ready, 1);
        tick();
        go_valid = 1'b0;
        chk("dnn_reset_cyc1", dnn_reset, 1);
        chk("dnn_start_cyc1", dnn_start, 0);
        tick();
        chk("dnn_start_cyc2", dnn_start, 1);
        chk("dnn_reset_cyc2", dnn_reset, 0);
        chk("go_ready_busy", go_ready, 0);
        n_start = cyc_cnt;
        n_done  = -1;
        got     = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == hreq_at) host_req = 1'b1;
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            if (host_req) chk("gnt_held_off", host_gnt, 0);
            if (dnn_done && n_done < 0) n_done = cyc_cnt;
        end
        chk("res_valid_seen", got, 1);
        want = sb.pop_front();
        if (got) begin
            if (delay >= 0) chk("done_to_valid_edges", cyc_cnt - n_done - 1, NC + 1);
            else            chk("run_cycles_to_timeout", cyc_cnt - n_start - 1, TMO);
            chk("res_class", res_class, want.cls);
            chk("res_score", res_score, want.score);
            chk("res_timeout", res_timeout, want.tmo);
            for (int b = 0; b < bp; b++) begin
                res_ready = 1'b0;
                tick();
                chk("bp_valid", res_valid, 1);
                chk("bp_class", res_class, want.cls);
                chk("bp_score", res_score, want.score);
                chk("bp_timeout", res_timeout, want.tmo);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("valid_after_hs", res_valid, 0);
            chk("go_ready_after_hs", go_ready, !host_req);
        end
    endtask

    initial begin
        int base_r;
        int base_s;
        rst          = 1'b1;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_wdata   = '0;
        go_valid     = 1'b0;
        res_ready    = 1'b0;
        dnn_mem_addr = 16'h1234;
        dnn_out      = '0;

        // Reset state
        tick();
        tick();
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_dnn_start", dnn_start, 0);
        chk("rst_dnn_reset", dnn_reset, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_res_class", res_class, 0);
        chk("rst_res_score", res_score, 0);
        chk("rst_go_ready", go_ready, 1);
        host_req = 1'b1;
        #1;
        chk("rst_go_ready_hreq", go_ready, 0);
        host_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Host load
        host_req = 1'b1;
        tick();
        host_we = 1'b1;
        #1;
        chk("load_gnt_cyc1", host_gnt, 0);
        chk("load_we_no_gnt", mem_we, 0);
        chk("load_addr_no_gnt", mem_addr, 16'h1234);
        tick();
        chk("load_gnt_cyc2", host_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            host_addr  = 16'(i);
            host_wdata = 8'(8'h10 + i);
            host_we    = 1'b1;
            #1;
            chk("wr_mem_we", mem_we, 1);
            chk("wr_mem_addr", mem_addr, 32'(i));
            chk("wr_mem_wdata", mem_wdata, 32'(8'h10 + i));
            tick();
        end
        host_we = 1'b0;
        #1;
        chk("wr_we_low", mem_we, 0);
        host_req = 1'b0;
        tick();
        chk("load_gnt_drop", host_gnt, 0);
        chk("load_go_ready", go_ready, 1);

        // Nominal job with tie at index 2/4, then backpressure
        cur_sc = '{5, -3, 40, 7, 40, 0, -128, 12, 1, 2};
        do_job(20, 5, -1);

        // Timeout
        do_job(-1, 0, -1);

        // Arbitration: host and go together in IDLE
        tick();
        host_req = 1'b1;
        go_valid = 1'b1;
        #1;
        chk("arb_go_ready", go_ready, 0);
        tick();
        go_valid = 1'b0;
        chk("arb_no_clear", dnn_reset, 0);
        tick();
        chk("arb_gnt", host_gnt, 1);
        chk("arb_no_start", dnn_start, 0);
        host_req = 1'b0;
        tick();
        chk("arb_gnt_drop", host_gnt, 0);

        // Host request during RUN waits for the result handshake
        cur_sc = '{-5, -7, -1, -1, -100, -128, -2, -3, -4, -9};
        do_job(20, 0, 5);
        chk("queued_gnt_idle", host_gnt, 0);
        tick();
        chk("queued_gnt_load1", host_gnt, 0);
        tick();
        chk("queued_gnt_load2", host_gnt, 1);
        host_req = 1'b0;
        tick();
        chk("queued_gnt_drop", host_gnt, 0);

        // All-equal scores resolve to index 0
        cur_sc = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
        do_job(7, 0, -1);

        // Reset mid-RUN
        eng_delay = -1;
        go_valid  = 1'b1;
        tick();
        go_valid = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_host_gnt", host_gnt, 0);
        chk("mid_rst_dnn_start", dnn_start, 0);
        chk("mid_rst_dnn_reset", dnn_reset, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_timeout", res_timeout, 0);
        chk("mid_rst_res_class", res_class, 0);
        chk("mid_rst_res_score", res_score, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_go_ready", go_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        base_r = n_rst_pulses;
        base_s = n_start_pulses;
        cur_sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
        do_job(20, 0, -1);
        chk("post_rst_reset_pulses", n_rst_pulses - base_r, 1);
        chk("post_rst_start_pulses", n_start_pulses - base_s, 1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
